// File: rtl/axis_frame_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_pkg
// Shared types and helpers for the AXI-Stream frame generator.
//   state_e     : generator FSM states (IDLE, SEND)
//   MAX_BYTES   : widest byte mask the helpers can produce (DATA_WIDTH <= 1024)
//   last_keep() : tkeep mask for the final beat of a packet of 'len' bytes
//   beat_count(): number of beats needed for 'len' bytes, ceil(len / bytes)
// -----------------------------------------------------------------------------
package axis_frame_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int MAX_BYTES = 128;

    // Final-beat mask: low (len mod bytes) lanes set, or every lane when the
    // length is an exact multiple of the beat width. Callers cast the result
    // down to their own lane count.
    function automatic logic [MAX_BYTES-1:0] last_keep(input logic [31:0] len,
                                                       input logic [31:0] bytes);
        logic [31:0]          rem_v;
        logic [31:0]          lim_v;
        logic [MAX_BYTES-1:0] mask_v;
        rem_v  = len % bytes;
        lim_v  = (rem_v == 32'd0) ? bytes : rem_v;
        mask_v = {MAX_BYTES{1'b0}};
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask_v[i] = (32'(i) < lim_v);
        end
        return mask_v;
    endfunction

    // Written as quotient plus remainder flag so it cannot overflow near the
    // top of the 32-bit range.
    function automatic logic [31:0] beat_count(input logic [31:0] len,
                                               input logic [31:0] bytes);
        logic [31:0] q_v;
        q_v = len / bytes;
        if ((len % bytes) != 32'd0) begin
            q_v = q_v + 32'd1;
        end else begin
            q_v = q_v;
        end
        return q_v;
    endfunction

endpackage

// File: rtl/axis_frame_gen_lane_fill.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_lane_fill
// Combinational payload pattern for one beat of the frame generator.
// Byte lane i of beat b = (start_byte + b*BYTES + i) mod 256.
// Ports:
//   start_byte [7:0]            value of payload byte 0 of the packet
//   beat_index [LEN_WIDTH-1:0]  beat number within the packet
//   pattern    [DATA_WIDTH-1:0] beat data, lane i at bits [8i+7:8i]
// -----------------------------------------------------------------------------
module axis_frame_gen_lane_fill #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [7:0]            start_byte,
    input  logic [LEN_WIDTH-1:0]  beat_index,
    output logic [DATA_WIDTH-1:0] pattern
);

    localparam int          BYTES   = DATA_WIDTH / 8;
    localparam logic [31:0] BYTES_U = 32'(BYTES);

    logic [7:0] base_s;

    // Only the low 8 bits of the byte offset survive the mod-256 wrap, so the
    // product is truncated before it is added to the start byte.
    always_comb begin
        base_s  = start_byte + 8'(32'(beat_index) * BYTES_U);
        pattern = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            pattern[8*i +: 8] = base_s + 8'(i);
        end
    end

endmodule

// File: rtl/axis_frame_generator.sv
// -----------------------------------------------------------------------------
// axis_frame_generator
// AXI-Stream packet transmitter: one command beat (length, start byte, TID,
// TDEST) becomes a framed packet with an incrementing-byte payload, tkeep on
// the final beat and tlast. Every output is driven straight from a register;
// m_axis_tready only feeds next-state logic.
// Ports:
//   aclk, areset_n               clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_len, cmd_start           byte length, value of payload byte 0
//   cmd_id, cmd_dest             tid / tdest for the whole packet
//   m_axis_t*                    AXI-Stream master (valid, ready, data, keep,
//                                last, id, dest)
//   busy                         packet in flight
//   err_zero_len                 one-cycle pulse when a zero-length command
//                                is accepted
// Build option AXIS_FRAME_GENERATOR_STATS_EN adds stat_pkts / stat_beats
// (32-bit wrapping counters of tlast handshakes and beat handshakes).
// -----------------------------------------------------------------------------
module axis_frame_generator
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int LEN_WIDTH   = 16,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [7:0]              cmd_start,
    input  logic [TID_WIDTH-1:0]    cmd_id,
    input  logic [TDEST_WIDTH-1:0]  cmd_dest,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [TID_WIDTH-1:0]    m_axis_tid,
    output logic [TDEST_WIDTH-1:0]  m_axis_tdest,
`ifdef AXIS_FRAME_GENERATOR_STATS_EN
    output logic [31:0]             stat_pkts,
    output logic [31:0]             stat_beats,
`endif
    output logic                    busy,
    output logic                    err_zero_len
);

    localparam int                   BYTES   = DATA_WIDTH / 8;
    localparam logic [31:0]          BYTES_U = 32'(BYTES);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO_L  = LEN_WIDTH'(0);
    localparam logic [BYTES-1:0]     ALL_K   = {BYTES{1'b1}};

    state_e                   state_r, state_s;
    logic                     cmd_ready_r, cmd_ready_s;
    logic                     tvalid_r, tvalid_s;
    logic [DATA_WIDTH-1:0]    tdata_r, tdata_s;
    logic [BYTES-1:0]         tkeep_r, tkeep_s;
    logic                     tlast_r, tlast_s;
    logic [TID_WIDTH-1:0]     tid_r, tid_s;
    logic [TDEST_WIDTH-1:0]   tdest_r, tdest_s;
    logic                     busy_r, busy_s;
    logic                     err_r, err_s;
    logic [LEN_WIDTH-1:0]     beat_idx_r, beat_idx_s;
    logic [LEN_WIDTH-1:0]     beats_total_r, beats_total_s;
    logic [7:0]               start_r, start_s;
    logic [BYTES-1:0]         keep_last_r, keep_last_s;

    logic [LEN_WIDTH-1:0]     cmd_beats_s;
    logic [BYTES-1:0]         cmd_keep_s;
    logic [7:0]               fill_start_s;
    logic [LEN_WIDTH-1:0]     fill_index_s;
    logic [DATA_WIDTH-1:0]    fill_data_s;
    logic                     beat_hs_s;

    axis_frame_gen_lane_fill #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_lane_fill (
        .start_byte (fill_start_s),
        .beat_index (fill_index_s),
        .pattern    (fill_data_s)
    );

    // Packet geometry of the command currently on the command port.
    always_comb begin
        cmd_beats_s = LEN_WIDTH'(beat_count(32'(cmd_len), BYTES_U));
        cmd_keep_s  = BYTES'(last_keep(32'(cmd_len), BYTES_U));
        beat_hs_s   = tvalid_r && m_axis_tready;
    end

    // Next-state and next-output logic; the pattern generator is pointed at
    // the beat that will be loaded on the coming edge.
    always_comb begin
        state_s       = state_r;
        cmd_ready_s   = cmd_ready_r;
        tvalid_s      = tvalid_r;
        tdata_s       = tdata_r;
        tkeep_s       = tkeep_r;
        tlast_s       = tlast_r;
        tid_s         = tid_r;
        tdest_s       = tdest_r;
        busy_s        = busy_r;
        err_s         = 1'b0;
        beat_idx_s    = beat_idx_r;
        beats_total_s = beats_total_r;
        start_s       = start_r;
        keep_last_s   = keep_last_r;
        fill_start_s  = start_r;
        fill_index_s  = beat_idx_r + ONE_L;

        case (state_r)
            IDLE: begin
                fill_start_s = cmd_start;
                fill_index_s = ZERO_L;
                if (cmd_valid && cmd_ready_r) begin
                    if (cmd_len == ZERO_L) begin
                        err_s = 1'b1;
                    end else begin
                        state_s       = SEND;
                        cmd_ready_s   = 1'b0;
                        busy_s        = 1'b1;
                        tvalid_s      = 1'b1;
                        tdata_s       = fill_data_s;
                        tlast_s       = (cmd_beats_s == ONE_L);
                        tkeep_s       = (cmd_beats_s == ONE_L) ? cmd_keep_s : ALL_K;
                        tid_s         = cmd_id;
                        tdest_s       = cmd_dest;
                        beat_idx_s    = ZERO_L;
                        beats_total_s = cmd_beats_s;
                        start_s       = cmd_start;
                        keep_last_s   = cmd_keep_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (beat_hs_s) begin
                    if (tlast_r) begin
                        state_s     = IDLE;
                        cmd_ready_s = 1'b1;
                        busy_s      = 1'b0;
                        tvalid_s    = 1'b0;
                        tlast_s     = 1'b0;
                    end else begin
                        beat_idx_s = beat_idx_r + ONE_L;
                        tdata_s    = fill_data_s;
                        tlast_s    = ((beat_idx_r + ONE_L) == (beats_total_r - ONE_L));
                        tkeep_s    = tlast_s ? keep_last_r : ALL_K;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s     = IDLE;
                cmd_ready_s = 1'b1;
                busy_s      = 1'b0;
                tvalid_s    = 1'b0;
                tlast_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_r       <= IDLE;
            cmd_ready_r   <= 1'b1;
            tvalid_r      <= 1'b0;
            tdata_r       <= {DATA_WIDTH{1'b0}};
            tkeep_r       <= {BYTES{1'b0}};
            tlast_r       <= 1'b0;
            tid_r         <= {TID_WIDTH{1'b0}};
            tdest_r       <= {TDEST_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
            beat_idx_r    <= ZERO_L;
            beats_total_r <= ZERO_L;
            start_r       <= 8'h00;
            keep_last_r   <= {BYTES{1'b0}};
        end else begin
            state_r       <= state_s;
            cmd_ready_r   <= cmd_ready_s;
            tvalid_r      <= tvalid_s;
            tdata_r       <= tdata_s;
            tkeep_r       <= tkeep_s;
            tlast_r       <= tlast_s;
            tid_r         <= tid_s;
            tdest_r       <= tdest_s;
            busy_r        <= busy_s;
            err_r         <= err_s;
            beat_idx_r    <= beat_idx_s;
            beats_total_r <= beats_total_s;
            start_r       <= start_s;
            keep_last_r   <= keep_last_s;
        end
    end

`ifdef AXIS_FRAME_GENERATOR_STATS_EN
    logic [31:0] stat_pkts_r;
    logic [31:0] stat_beats_r;

    // Handshake counters, free-running with natural 32-bit wrap.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            stat_pkts_r  <= 32'd0;
            stat_beats_r <= 32'd0;
        end else if (beat_hs_s) begin
            stat_beats_r <= stat_beats_r + 32'd1;
            stat_pkts_r  <= stat_pkts_r + (tlast_r ? 32'd1 : 32'd0);
        end else begin
            stat_beats_r <= stat_beats_r;
            stat_pkts_r  <= stat_pkts_r;
        end
    end

    assign stat_pkts  = stat_pkts_r;
    assign stat_beats = stat_beats_r;
`endif

    assign cmd_ready     = cmd_ready_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tid    = tid_r;
    assign m_axis_tdest  = tdest_r;
    assign busy          = busy_r;
    assign err_zero_len  = err_r;

endmodule
